// File: rtl/tia_player_position_counter_pkg.sv
// -----------------------------------------------------------------------------
// tia_player_position_counter_pkg
//
// Shared definitions for the player horizontal position counter:
//   - LINE_CLOCKS: visible colour clocks per line (counter modulus)
//   - NUSIZ encodings (number/size field of NUSIZx)
//   - copy offsets (16, 32, 64 colour clocks after the main copy)
//   - width_enable(): count_bar qualification for double/quad width players
// -----------------------------------------------------------------------------
package tia_player_position_counter_pkg;

    localparam int unsigned LINE_CLOCKS = 160;
    localparam logic [7:0]  LAST_POS    = 8'(LINE_CLOCKS - 1);

    localparam logic [7:0] COPY_OFFSET_CLOSE = 8'd16;
    localparam logic [7:0] COPY_OFFSET_MED   = 8'd32;
    localparam logic [7:0] COPY_OFFSET_WIDE  = 8'd64;

    typedef enum logic [2:0] {
        NUSIZ_ONE         = 3'b000,
        NUSIZ_TWO_CLOSE   = 3'b001,
        NUSIZ_TWO_MED     = 3'b010,
        NUSIZ_THREE_CLOSE = 3'b011,
        NUSIZ_TWO_WIDE    = 3'b100,
        NUSIZ_DOUBLE      = 3'b101,
        NUSIZ_THREE_MED   = 3'b110,
        NUSIZ_QUAD        = 3'b111
    } nusiz_e;

    // High when the scan counter may advance on this tick. Double width
    // advances on every second tick, quad width on every fourth.
    function automatic logic width_enable(input logic [2:0] nusiz,
                                          input logic [1:0] prescaler);
        logic en;
        case (nusiz_e'(nusiz))
            NUSIZ_DOUBLE: en = prescaler[0];
            NUSIZ_QUAD:   en = (prescaler == 2'd3);
            default:      en = 1'b1;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/tia_player_copy_decode.sv
// -----------------------------------------------------------------------------
// tia_player_copy_decode
//
// Purely combinational decode of the position the counter is about to take.
//   next_position_i : position after this edge (0..159)
//   nusiz_i         : NUSIZx number/size field
//   main_match_o    : next position is 0 (start of the main copy)
//   copy_match_o    : next position is one of the copy offsets for nusiz_i
// The caller qualifies both flags with tick/resp/armed state.
// -----------------------------------------------------------------------------
module tia_player_copy_decode
    import tia_player_position_counter_pkg::*;
(
    input  logic [7:0] next_position_i,
    input  logic [2:0] nusiz_i,
    output logic       main_match_o,
    output logic       copy_match_o
);

    logic at_close;
    logic at_med;
    logic at_wide;

    assign at_close = (next_position_i == COPY_OFFSET_CLOSE);
    assign at_med   = (next_position_i == COPY_OFFSET_MED);
    assign at_wide  = (next_position_i == COPY_OFFSET_WIDE);

    assign main_match_o = (next_position_i == 8'd0);

    // NOTE: every output of an always_comb gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        copy_match_o = 1'b0;
        case (nusiz_e'(nusiz_i))
            NUSIZ_TWO_CLOSE:   copy_match_o = at_close;
            NUSIZ_TWO_MED:     copy_match_o = at_med;
            NUSIZ_THREE_CLOSE: copy_match_o = at_close | at_med;
            NUSIZ_TWO_WIDE:    copy_match_o = at_wide;
            NUSIZ_THREE_MED:   copy_match_o = at_med | at_wide;
            default:           copy_match_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/tia_player_position_counter.sv
// -----------------------------------------------------------------------------
// tia_player_position_counter
//
// Horizontal position counter for one TIA player object. Counts motion-clock
// ticks modulo 160 and produces the start/advance strobes for the player
// graphics scan counter.
//
// Ports:
//   clkp        in  colour clock, all state changes on the rising edge
//   reset       in  synchronous, active-high reset
//   motck       in  motion-clock enable (visible colour clocks)
//   hmove_extra in  extra motion-clock pulse from HMOVE logic during HBLANK
//   resp        in  RESPx strobe, one clkp wide; reloads position to 0
//   nusiz       in  NUSIZx number/size field
//   start_bar   out active-low start strobe to the scan counter (registered)
//   count_bar   out active-low advance enable to the scan counter (registered)
//   position    out current horizontal position 0..159 (debug)
// -----------------------------------------------------------------------------
module tia_player_position_counter
    import tia_player_position_counter_pkg::*;
(
    input  logic       clkp,
    input  logic       reset,
    input  logic       motck,
    input  logic       hmove_extra,
    input  logic       resp,
    input  logic [2:0] nusiz,
    output logic       start_bar,
    output logic       count_bar,
    output logic [7:0] position
);

    logic [7:0] position_q,     position_d;
    logic [1:0] prescaler_q,    prescaler_d;
    logic       copies_armed_q, copies_armed_d;
    logic       start_bar_q,    start_bar_d;
    logic       count_bar_q,    count_bar_d;

    logic tick;
    logic start;
    logic main_match;
    logic copy_match;

    // Both enables together still move the object by one clock.
    assign tick = motck | hmove_extra;

    tia_player_copy_decode u_copy_decode (
        .next_position_i (position_d),
        .nusiz_i         (nusiz),
        .main_match_o    (main_match),
        .copy_match_o    (copy_match)
    );

    always_comb begin
        position_d = position_q;
        if (resp) begin
            position_d = 8'd0;
        end else if (tick) begin
            position_d = (position_q == LAST_POS) ? 8'd0 : position_q + 8'd1;
        end
    end

    // With tick and no resp, next position 0 can only come from the 159->0
    // wrap. The resp load also lands on 0 but must not start the main copy.
    // Copies stay disabled from reset until the first resp has placed the
    // object; after that they remain enabled until the next reset.
    always_comb begin
        start          = tick & ~resp & (main_match | (copies_armed_q & copy_match));
        copies_armed_d = copies_armed_q | resp;
        start_bar_d    = ~start;
        count_bar_d    = ~(tick & width_enable(nusiz, prescaler_q));

        prescaler_d = prescaler_q;
        if (start) begin
            prescaler_d = 2'd0;
        end else if (tick) begin
            prescaler_d = prescaler_q + 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clkp) begin
        if (reset) begin
            position_q     <= 8'd0;
            prescaler_q    <= 2'd0;
            copies_armed_q <= 1'b0;
            start_bar_q    <= 1'b1;
            count_bar_q    <= 1'b1;
        end else begin
            position_q     <= position_d;
            prescaler_q    <= prescaler_d;
            copies_armed_q <= copies_armed_d;
            start_bar_q    <= start_bar_d;
            count_bar_q    <= count_bar_d;
        end
    end

    assign start_bar = start_bar_q;
    assign count_bar = count_bar_q;
    assign position  = position_q;

endmodule
